// File: rtl/pipe_collision.sv
`default_nettype none
// ============================================================================
// Module      : pipe_collision
// Description : Scrolls two pipe pairs right-to-left, tests the bird box
//               against both pipes every cycle and raises Collision (which
//               stops the physics stage). Counts pipes passed. Shares the
//               Initial/Run/Over Start/Ack handshake with the physics block.
//               Optional build macro: FLOOR_KILL_EN (bird touching the floor
//               row SCREEN_H is also a hit).
// Revision    : 1.0 - initial release
// ============================================================================
module pipe_collision #(
    parameter int          SCREEN_W     = 640,
    parameter int          SCREEN_H     = 480,
    parameter int          PIPE_W       = 40,
    parameter int          GAP_H        = 120,
    parameter int          PIPE_SPACING = 320,
    parameter int          SCROLL_STEP  = 2,
    parameter logic [9:0]  LFSR_SEED    = 10'h1A5
) (
    input  logic       Clk,
    input  logic       reset,
    input  logic       Start,
    input  logic       Ack,
    input  logic       Tick,
    input  logic [9:0] Bird_X_L,
    input  logic [9:0] Bird_X_R,
    input  logic [9:0] Bird_Y_T,
    input  logic [9:0] Bird_Y_B,
    output logic [9:0] Pipe0_X,
    output logic [9:0] Pipe1_X,
    output logic [9:0] Pipe0_GapT,
    output logic [9:0] Pipe1_GapT,
    output logic [7:0] Score,
    output logic       Collision,
    output logic       q_Initial,
    output logic       q_Run,
    output logic       q_Over
);

    // One-hot state encoding
    localparam logic [2:0] c_st_initial = 3'b001;
    localparam logic [2:0] c_st_run     = 3'b010;
    localparam logic [2:0] c_st_over    = 3'b100;

    // Geometry constants, widened to 11 bits so edge sums never wrap
    localparam logic [9:0]  c_x0_init   = 10'(SCREEN_W);
    localparam logic [9:0]  c_x1_init   = 10'(SCREEN_W + PIPE_SPACING);
    localparam logic [10:0] c_pipe_w    = 11'(PIPE_W);
    localparam logic [10:0] c_gap_h     = 11'(GAP_H);
    localparam logic [10:0] c_step      = 11'(SCROLL_STEP);
    localparam logic [10:0] c_respawn   = 11'(2 * PIPE_SPACING - SCROLL_STEP);
    localparam logic [10:0] c_screen_h  = 11'(SCREEN_H);
    localparam logic [9:0]  c_gap_base  = 10'd40;
    localparam logic [9:0]  c_gap_seed  = c_gap_base + {2'b00, LFSR_SEED[7:0]};

`ifdef FLOOR_KILL_EN
    localparam logic c_floor_kill = 1'b1;
`else
    localparam logic c_floor_kill = 1'b0;
`endif

    logic [2:0]       r_state;
    logic [9:0]       r_lfsr;
    logic [1:0][9:0]  r_pipe_x;
    logic [1:0][9:0]  r_gap_t;
    logic [7:0]       r_score;
    logic             r_collision;

    logic [9:0]       w_lfsr_next;
    logic [9:0]       w_gap_new;
    logic [1:0]       w_hit;
    logic [1:0]       w_pass;
    logic [1:0]       w_respawn;
    logic [1:0][9:0]  w_next_x;
    logic             w_floor;
    logic             w_hit_any;
    logic [1:0]       w_pass_cnt;
    logic [8:0]       w_score_sum;
    logic [7:0]       w_score_next;

    logic [10:0]      w_bxl;
    logic [10:0]      w_bxr;
    logic [10:0]      w_byt;
    logic [10:0]      w_byb;

    assign w_bxl = {1'b0, Bird_X_L};
    assign w_bxr = {1'b0, Bird_X_R};
    assign w_byt = {1'b0, Bird_Y_T};
    assign w_byb = {1'b0, Bird_Y_B};

    // Fibonacci LFSR x^10 + x^7 + 1, shifting towards the MSB
    assign w_lfsr_next = {r_lfsr[8:0], r_lfsr[9] ^ r_lfsr[6]};
    assign w_gap_new   = c_gap_base + {2'b00, r_lfsr[7:0]};

    // Per-pipe hit test, scroll/respawn position and pass detection
    generate
        for (genvar i = 0; i < 2; i++) begin : g_pipe
            logic [10:0] w_x;
            logic [10:0] w_right;
            logic [10:0] w_gap_top;
            logic [10:0] w_gap_bot;
            logic [10:0] w_nx;

            assign w_x       = {1'b0, r_pipe_x[i]};
            assign w_right   = w_x + c_pipe_w;
            assign w_gap_top = {1'b0, r_gap_t[i]};
            assign w_gap_bot = w_gap_top + c_gap_h;

            assign w_hit[i] = (w_bxr > w_x) && (w_bxl < w_right) &&
                              ((w_byt < w_gap_top) || (w_byb > w_gap_bot));

            assign w_respawn[i] = (w_x < c_step);
            assign w_nx         = w_respawn[i] ? (w_x + c_respawn) : (w_x - c_step);
            assign w_next_x[i]  = w_nx[9:0];

            // The trailing edge crosses the bird's left edge on this tick
            assign w_pass[i] = (w_right >= w_bxl) && ((w_nx + c_pipe_w) < w_bxl);
        end
    endgenerate

    assign w_floor   = (w_byb >= c_screen_h);
    assign w_hit_any = (|w_hit) || (c_floor_kill && w_floor);

    // Saturating score add; two passes on one tick add two
    assign w_pass_cnt   = {1'b0, w_pass[0]} + {1'b0, w_pass[1]};
    assign w_score_sum  = {1'b0, r_score} + {7'b0, w_pass_cnt};
    assign w_score_next = w_score_sum[8] ? 8'hFF : w_score_sum[7:0];

    // Game state: Start leaves Initial, a hit ends Run, Ack leaves Over
    always_ff @(posedge Clk) begin
        if (reset) begin
            r_state <= c_st_initial;
        end else begin
            case (r_state)
                c_st_initial: if (Start)     r_state <= c_st_run;
                c_st_run:     if (w_hit_any) r_state <= c_st_over;
                c_st_over:    if (Ack)       r_state <= c_st_initial;
                default:                     r_state <= c_st_initial;
            endcase
        end
    end

    // Free-running gap generator, advances in every state
    always_ff @(posedge Clk) begin
        if (reset) begin
            r_lfsr <= LFSR_SEED;
        end else begin
            r_lfsr <= w_lfsr_next;
        end
    end

    // Pipe positions, gaps, score and collision flag; a hit beats a tick
    always_ff @(posedge Clk) begin
        if (reset) begin
            r_pipe_x[0] <= c_x0_init;
            r_pipe_x[1] <= c_x1_init;
            r_gap_t[0]  <= c_gap_seed;
            r_gap_t[1]  <= c_gap_seed;
            r_score     <= 8'd0;
            r_collision <= 1'b0;
        end else begin
            case (r_state)
                c_st_run: begin
                    if (w_hit_any) begin
                        r_collision <= 1'b1;
                    end else if (Tick) begin
                        for (int i = 0; i < 2; i++) begin
                            r_pipe_x[i] <= w_next_x[i];
                            if (w_respawn[i]) begin
                                r_gap_t[i] <= w_gap_new;
                            end
                        end
                        r_score <= w_score_next;
                    end
                end
                c_st_over: begin
                    // Frozen until Ack, which reloads the Initial values
                    if (Ack) begin
                        r_pipe_x[0] <= c_x0_init;
                        r_pipe_x[1] <= c_x1_init;
                        r_gap_t[0]  <= w_gap_new;
                        r_gap_t[1]  <= w_gap_new;
                        r_score     <= 8'd0;
                        r_collision <= 1'b0;
                    end
                end
                default: begin
                    // Initial (and recovery from an illegal state)
                    r_pipe_x[0] <= c_x0_init;
                    r_pipe_x[1] <= c_x1_init;
                    r_gap_t[0]  <= w_gap_new;
                    r_gap_t[1]  <= w_gap_new;
                    r_score     <= 8'd0;
                    r_collision <= 1'b0;
                end
            endcase
        end
    end

    assign Pipe0_X    = r_pipe_x[0];
    assign Pipe1_X    = r_pipe_x[1];
    assign Pipe0_GapT = r_gap_t[0];
    assign Pipe1_GapT = r_gap_t[1];
    assign Score      = r_score;
    assign Collision  = r_collision;
    assign q_Initial  = r_state[0];
    assign q_Run      = r_state[1];
    assign q_Over     = r_state[2];

endmodule
`default_nettype wire

// File: tb/tb_pipe_collision.sv
`default_nettype none
// ============================================================================
// Module      : tb_pipe_collision
// Description : Scoreboard bench for pipe_collision. A game-level reference
//               model predicts every output after each edge; predictions are
//               queued by the driver and compared by an independent monitor.
//               Honours FLOOR_KILL_EN in the model.
// Revision    : 1.0 - initial release
// ============================================================================
module tb_pipe_collision;

    logic       Clk = 1'b0;
    logic       reset, Start, Ack, Tick;
    logic [9:0] Bird_X_L, Bird_X_R, Bird_Y_T, Bird_Y_B;
    logic [9:0] Pipe0_X, Pipe1_X, Pipe0_GapT, Pipe1_GapT;
    logic [7:0] Score;
    logic       Collision, q_Initial, q_Run, q_Over;

    always #5 Clk = ~Clk;

    pipe_collision dut (
        .Clk        (Clk),
        .reset      (reset),
        .Start      (Start),
        .Ack        (Ack),
        .Tick       (Tick),
        .Bird_X_L   (Bird_X_L),
        .Bird_X_R   (Bird_X_R),
        .Bird_Y_T   (Bird_Y_T),
        .Bird_Y_B   (Bird_Y_B),
        .Pipe0_X    (Pipe0_X),
        .Pipe1_X    (Pipe1_X),
        .Pipe0_GapT (Pipe0_GapT),
        .Pipe1_GapT (Pipe1_GapT),
        .Score      (Score),
        .Collision  (Collision),
        .q_Initial  (q_Initial),
        .q_Run      (q_Run),
        .q_Over     (q_Over)
    );

    typedef struct {
        int x0; int x1; int g0; int g1; int score; int col; int st;
    } exp_t;

    exp_t exp_q[$];
    int   checks   = 0;
    int   failures = 0;

    // Reference model: game state 0=Initial 1=Run 2=Over
    int m_state, m_score, m_col, m_lfsr;
    int m_x[2];
    int m_gap[2];

    task automatic chk(input string name, input int act, input int req);
        checks++;
        if (act != req) begin
            failures++;
            $display("FAIL %s actual=%0d required=%0d at %0t", name, act, req, $time);
        end
    endtask

    function automatic int lfsr_step(input int v);
        return ((v << 1) & 1023) | (((v >> 9) ^ (v >> 6)) & 1);
    endfunction

    task automatic model_step(input bit r, input bit s, input bit a, input bit t);
        int  gnew, passes, ox, nx;
        int  bxl, bxr, byt, byb;
        bit  hit;
        bxl = int'(Bird_X_L); bxr = int'(Bird_X_R);
        byt = int'(Bird_Y_T); byb = int'(Bird_Y_B);
        if (r) begin
            m_state = 0; m_x[0] = 640; m_x[1] = 960;
            m_gap[0] = 40 + ('h1A5 & 255); m_gap[1] = m_gap[0];
            m_score = 0; m_col = 0; m_lfsr = 'h1A5;
        end else begin
            gnew = 40 + (m_lfsr & 255);
            if (m_state == 0) begin
                m_x[0] = 640; m_x[1] = 960; m_gap[0] = gnew; m_gap[1] = gnew;
                m_score = 0; m_col = 0;
                if (s) m_state = 1;
            end else if (m_state == 1) begin
                hit = 0;
                for (int p = 0; p < 2; p++)
                    if (bxr > m_x[p] && bxl < m_x[p] + 40 &&
                        (byt < m_gap[p] || byb > m_gap[p] + 120)) hit = 1;
`ifdef FLOOR_KILL_EN
                if (byb >= 480) hit = 1;
`endif
                if (hit) begin
                    m_col = 1; m_state = 2;
                end else if (t) begin
                    passes = 0;
                    for (int p = 0; p < 2; p++) begin
                        ox = m_x[p];
                        if (ox < 2) begin nx = ox + 638; m_gap[p] = gnew; end
                        else nx = ox - 2;
                        if (ox + 40 >= bxl && nx + 40 < bxl) passes++;
                        m_x[p] = nx;
                    end
                    m_score = (m_score + passes > 255) ? 255 : m_score + passes;
                end
            end else if (a) begin
                m_state = 0; m_x[0] = 640; m_x[1] = 960; m_gap[0] = gnew; m_gap[1] = gnew;
                m_score = 0; m_col = 0;
            end
            m_lfsr = lfsr_step(m_lfsr);
        end
    endtask

    // One clock: apply inputs, predict, queue the prediction after the edge
    task automatic cyc(input bit r, input bit s, input bit a, input bit t);
        exp_t e;
        reset = r; Start = s; Ack = a; Tick = t;
        model_step(r, s, a, t);
        @(posedge Clk);
        #1;
        e.x0 = m_x[0]; e.x1 = m_x[1]; e.g0 = m_gap[0]; e.g1 = m_gap[1];
        e.score = m_score; e.col = m_col; e.st = m_state;
        exp_q.push_back(e);
        @(negedge Clk);
        #1;
    endtask

    task automatic bird(input int xl, input int xr, input int yt, input int yb);
        Bird_X_L = 10'(xl); Bird_X_R = 10'(xr); Bird_Y_T = 10'(yt); Bird_Y_B = 10'(yb);
    endtask

    // Monitor: compare DUT outputs with the oldest prediction
    always @(negedge Clk) begin
        if (exp_q.size() > 0) begin
            exp_t e;
            e = exp_q.pop_front();
            chk("sb_pipe0_x", int'(Pipe0_X), e.x0);
            chk("sb_pipe1_x", int'(Pipe1_X), e.x1);
            chk("sb_pipe0_gapt", int'(Pipe0_GapT), e.g0);
            chk("sb_pipe1_gapt", int'(Pipe1_GapT), e.g1);
            chk("sb_score", int'(Score), e.score);
            chk("sb_collision", int'(Collision), e.col);
            chk("sb_state", int'({q_Over, q_Run, q_Initial}), 1 << e.st);
        end
    end

    initial begin
        int p, fl_exp;
        bird(0, 0, 0, 0);
        reset = 1'b1; Start = 1'b0; Ack = 1'b0; Tick = 1'b0;

        // Reset state
        cyc(1, 0, 0, 0); cyc(1, 0, 0, 0);
        chk("rst_pipe0_x", int'(Pipe0_X), 640);
        chk("rst_pipe1_x", int'(Pipe1_X), 960);
        chk("rst_gapt0", int'(Pipe0_GapT), 205);
        chk("rst_gapt1", int'(Pipe1_GapT), 205);
        chk("rst_score", int'(Score), 0);
        chk("rst_initial", int'(q_Initial), 1);

        // Bird beside the pipe path, 185 ticks
        cyc(0, 1, 0, 0);
        bird(250, 270, 220, 240);
        repeat (185) cyc(0, 0, 0, 1);
        chk("plan1_pipe0_x", int'(Pipe0_X), 270);
        chk("plan1_collision", int'(Collision), 0);

        // Bird in the gap: one pass, then respawn
        cyc(1, 0, 0, 0); cyc(0, 1, 0, 0);
        bird(250, 270, m_gap[0] + 10, m_gap[0] + 30);
        repeat (216) cyc(0, 0, 0, 1);
        chk("plan2_pipe0_x", int'(Pipe0_X), 208);
        chk("plan2_score", int'(Score), 1);
        chk("plan2_collision", int'(Collision), 0);
        repeat (105) cyc(0, 0, 0, 1);
        chk("plan3_pipe0_x", int'(Pipe0_X), 638);
        chk("plan3_pipe1_x", int'(Pipe1_X), 318);
        chk("plan3_spacing", int'(Pipe0_X) - int'(Pipe1_X), 320);

        // Bird above the opening: hit at X=268, hit wins over a tick
        cyc(1, 0, 0, 0); cyc(0, 1, 0, 0);
        bird(250, 270, 0, 20);
        for (int i = 0; i < 400 && m_x[0] != 268; i++) cyc(0, 0, 0, 1);
        chk("plan4_pre_x", int'(Pipe0_X), 268);
        chk("plan4_pre_col", int'(Collision), 0);
        cyc(0, 1, 0, 1);
        chk("plan4_col", int'(Collision), 1);
        chk("plan4_over", int'(q_Over), 1);
        chk("plan4_tick_lost", int'(Pipe0_X), 268);
        repeat (5) cyc(0, 1, 0, 1);
        chk("plan4_frozen_x", int'(Pipe0_X), 268);
        cyc(0, 1, 1, 0);
        chk("plan4_ack_initial", int'(q_Initial), 1);
        chk("plan4_ack_score", int'(Score), 0);
        chk("plan4_ack_x", int'(Pipe0_X), 640);
        cyc(0, 1, 0, 0);
        chk("plan4_restart_run", int'(q_Run), 1);

        // Reset in the middle of a run
        bird(250, 270, m_gap[0] + 10, m_gap[0] + 30);
        repeat (10) cyc(0, 0, 0, 1);
        cyc(1, 0, 0, 1);
        chk("midrst_x0", int'(Pipe0_X), 640);
        chk("midrst_x1", int'(Pipe1_X), 960);
        chk("midrst_gap", int'(Pipe0_GapT), 205);
        chk("midrst_initial", int'(q_Initial), 1);

        // Bird resting on the floor, no pipe overlap
`ifdef FLOOR_KILL_EN
        fl_exp = 1;
`else
        fl_exp = 0;
`endif
        cyc(0, 1, 0, 0);
        bird(250, 270, 440, 480);
        cyc(0, 0, 0, 0);
        chk("floor_first", int'(Collision), fl_exp);
        repeat (100) cyc(0, 0, 0, 1);
        chk("floor_100", int'(Collision), fl_exp);

        // Long flight tracking each gap, drives Score into saturation
        cyc(1, 0, 0, 0); cyc(0, 1, 0, 0);
        for (int i = 0; i < 42000; i++) begin
            p = ((m_x[0] > 250 ? m_x[0] - 250 : 250 - m_x[0]) <
                 (m_x[1] > 250 ? m_x[1] - 250 : 250 - m_x[1])) ? 0 : 1;
            bird(250, 270, m_gap[p] + 10, m_gap[p] + 30);
            cyc(0, 0, 0, 1);
        end
        chk("sat_score", int'(Score), 255);
        chk("sat_collision", int'(Collision), 0);

        // Randomized play
        for (int i = 0; i < 4000; i++) begin
            if (i % 40 == 0) begin
                int xl, yt;
                xl = $urandom_range(0, 600);
                if ($urandom_range(0, 1) == 1) begin
                    yt = m_gap[$urandom_range(0, 1)] + $urandom_range(0, 60);
                    bird(xl, xl + $urandom_range(5, 30), yt, yt + $urandom_range(10, 40));
                end else begin
                    yt = $urandom_range(0, 440);
                    bird(xl, xl + $urandom_range(5, 30), yt, yt + $urandom_range(10, 40));
                end
            end
            cyc($urandom_range(0, 299) == 0, $urandom_range(0, 7) == 0,
                $urandom_range(0, 7) == 0, $urandom_range(0, 1) == 1);
        end

        repeat (2) @(negedge Clk);
        chk("queue_drained", exp_q.size(), 0);
        $display("TB_RESULT checks=%0d failures=%0d", checks, failures);
        $finish;
    end

endmodule
`default_nettype wire

// File: doc/pipe_collision.md
# pipe_collision

Downstream companion to the flight-physics stage. Scrolls two pipe pairs right-to-left, tests the bird bounding box against them every cycle and raises `Collision` (wired to the physics block's `Stop`). Also counts pipes passed. Runs the same Initial/Run/Over handshake as the physics block, so both share `Start`/`Ack`.

## Interface
Parameters:
- `SCREEN_W`, 640, visible width in pixels
- `SCREEN_H`, 480, visible height in pixels
- `PIPE_W`, 40, pipe width in pixels
- `GAP_H`, 120, vertical opening height in pixels
- `PIPE_SPACING`, 320, horizontal distance between the two pipes
- `SCROLL_STEP`, 2, pixels moved per `Tick`
- `LFSR_SEED`, 10'h1A5, nonzero LFSR reset value

Ports. One clock; reset is synchronous and active-high (`Clk`, `reset`).
- `Clk` in 1: system clock
- `reset` in 1: synchronous, active-high
- `Start` in 1: level; leave Initial
- `Ack` in 1: level; leave Over
- `Tick` in 1: one-cycle scroll strobe, one per frame step
- `Bird_X_L`, `Bird_X_R`, `Bird_Y_T`, `Bird_Y_B` in 10 each: bird box from the physics stage
- `Pipe0_X`, `Pipe1_X` out 10 each: pipe left edges
- `Pipe0_GapT`, `Pipe1_GapT` out 10 each: top row of each opening
- `Score` out 8: pipes passed
- `Collision` out 1: level; high only in Over
- `q_Initial`, `q_Run`, `q_Over` out 1 each: one-hot state

## Operation
- State is held one-hot in 3 bits: Initial=001, Run=010, Over=100. An illegal state recovers to Initial on the next edge.
- **LFSR**
  - 10-bit Fibonacci LFSR, polynomial x^10+x^7+1.
  - Advances every cycle in every state.
  - A new gap value is `40 + lfsr[7:0]`, giving a range of 40..295, so `GapT+GAP_H` is never more than 415.
- **Initial**
  - `Pipe0_X=SCREEN_W` (640) and `Pipe1_X=SCREEN_W+PIPE_SPACING` (960).
  - Both GapT values are reloaded from the LFSR every cycle.
  - `Score=0`, `Collision=0`.
  - `Start` moves to Run.
- **Run, on `Tick`**
  - Each pipe: if `X < SCROLL_STEP`, then `X <= X + 2*PIPE_SPACING - SCROLL_STEP` and GapT is reloaded from the LFSR (respawn). Otherwise `X <= X - SCROLL_STEP`.
  - Pass: if old `X+PIPE_W >= Bird_X_L` and new `X+PIPE_W < Bird_X_L`, `Score` increments. It saturates at 255.
  - Two passes on the same tick add 2.
- **Run, every cycle: hit test**
  - A pipe is hit when `Bird_X_R > X`, `Bird_X_L < X+PIPE_W`, and either `Bird_Y_T < GapT` or `Bird_Y_B > GapT+GAP_H`.
  - On a hit: next edge `Collision<=1`, state goes to Over.
  - Compares use 11-bit intermediates, so `X+PIPE_W` does not wrap.
- **Over**
  - Pipes, GapT and `Score` are frozen; `Collision` stays 1.
  - `Ack` moves to Initial.
- **Ignored inputs:** `Start` outside Initial, `Ack` outside Over, `Tick` outside Run.

## Timing
- Reset values, applied on the first `Clk` edge with `reset`=1:
  - state Initial
  - `Pipe0_X=640`, `Pipe1_X=960`
  - both GapT = `40+LFSR_SEED[7:0]` (205)
  - `Score=0`, `Collision=0`
  - LFSR = `LFSR_SEED`
- `reset` in any state, mid-run included, gives exactly these values on the next edge.
- Hit latency: positions that overlap at edge N produce `Collision`=1 and `q_Over`=1 after edge N+1.
- Hit and `Tick` in the same cycle: the hit wins. The tick's movement, respawn and score change are all discarded.
- Hit test uses registered pipe positions and the current bird inputs. There is no combinational path from the inputs to any output.
- `Start` held through Over is ignored. After `Ack`, one cycle is spent in Initial before Run, even if `Start` is still high.

## Configuration
- `FLOOR_KILL_EN` defined: `Bird_Y_B >= SCREEN_H` is also a hit, with the same one-cycle latency into Over.
- Undefined: only pipes cause a hit, and a bird resting at the floor (Y_B=480) keeps playing.

## Test plan
- Reset then `Start`, bird box X 250..270 / Y 220..240, 185 `Tick`s -> `Pipe0_X=270`, `Collision=0`.
- Same setup, bird placed inside the gap (Y_T=`Pipe0_GapT`+10, Y_B=`Pipe0_GapT`+30), 216 ticks -> `Pipe0_X=208`, `Score=1`, `Collision=0`.
- Bird kept in the gap, 321 ticks -> `Pipe0_X=638` with a new GapT, `Pipe1_X=318`; spacing stays 320.
- Bird Y_T=0 / Y_B=20 against GapT≥40, tick until `Pipe0_X=268` -> `Collision=1` and `q_Over=1` one cycle later. Further ticks leave `Pipe0_X` unchanged. `Ack` -> `q_Initial`, `Score=0`, `Pipe0_X=640`.
- Hit and `Tick` in the same cycle -> pipe X unchanged, `Collision=1`. Separately, `reset` mid-run -> all reset values on the next edge.
- With `FLOOR_KILL_EN`: Y_B=480, no pipe overlap -> `Collision=1` after 1 cycle. Without it: `Collision=0` for 100 ticks.
